// File: rtl/cdc_bus_tx_if.sv
// Bus bundle for cdc_bus_tx: source-side valid/ready word intake
// plus the toggle-handshake link toward the far clock domain.
interface cdc_bus_tx_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic [N-1:0] tx_data;
  logic         tx_req;
  logic         rx_ack;
  logic         done;
  logic         err;
  logic [15:0]  xfer_count;

  modport slave (
    input  in_valid, in_data, rx_ack,
    output in_ready, tx_data, tx_req,
    output done, err, xfer_count
  );

  modport master (
    output in_valid, in_data, rx_ack,
    input  in_ready, tx_data, tx_req,
    input  done, err, xfer_count
  );
endinterface

// File: rtl/cdc_bus_tx.sv
// Toggle-handshake bus transmitter: holds a word stable on tx_data
// and flips tx_req, then waits for the synchronized rx_ack to match.
module cdc_bus_tx #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  cdc_bus_tx_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N-1:0]           tx_data_q, tx_data_d;
  logic                   tx_req_q, tx_req_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic                   ack_s;
  logic                   timeout_hit;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.rx_ack};

  // Wait counter saturates, so the flag stays asserted once reached.
  assign timeout_hit = (TIMEOUT > 0) &&
                       (wait_q >= WW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
    done_d    = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    unique case (state_q)
      IDLE: begin
        if (ack_s != tx_req_q)
          err_d = 1'b1;
        if (bus.in_valid) begin
          tx_data_d = bus.in_data;
          tx_req_d  = ~tx_req_q;
          wait_d    = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (wait_q != '1)
          wait_d = wait_q + 1'b1;
        if (timeout_hit)
          err_d = 1'b1;
        if (ack_s == tx_req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_cdc_bus_tx.sv
// Scoreboard bench for cdc_bus_tx: words queued on drive, popped on done,
// with an inline far-end responder and timing checks.
module tb_cdc_bus_tx;
  logic clk;
  logic rst;

  cdc_bus_tx_if #(.N(8)) ifc ();

  cdc_bus_tx #(
    .N(8),
    .SYNC_STAGES(2),
    .TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          ndone    = 0;
  int          cyc      = 0;
  int          last_acc = -1;
  int          rdly     = 0;
  bit          resp_en  = 0;
  bit          space_en = 0;
  bit          prev_wait = 0;
  logic [7:0]  held     = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (ifc.done) begin
      ndone++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(ifc.tx_data), 32'(e));
      end
    end
    if (!ifc.in_ready && prev_wait)
      chk("tx_stable", 32'(ifc.tx_data), 32'(held));
    if (!ifc.in_ready && !prev_wait) begin
      if (space_en && last_acc >= 0)
        chk("spacing", 32'(cyc - last_acc >= 4), 32'd1);
      last_acc = cyc;
      held = ifc.tx_data;
    end
    prev_wait = !ifc.in_ready;
    if (resp_en && ifc.rx_ack != ifc.tx_req) begin
      if (rdly >= 1) begin
        ifc.rx_ack = ifc.tx_req;
        rdly = 0;
      end else begin
        rdly++;
      end
    end else begin
      rdly = 0;
    end
  endtask

  task automatic send(input logic [7:0] w);
    bit seen;
    bit ok;
    seen = ifc.in_ready;
    ok = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = w;
    exp_q.push_back(w);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (ifc.in_ready) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_count(input int target, input int max);
    for (int i = 0; i < max; i++) begin
      if (ndone >= target) break;
      tick();
    end
    chk("done_reached", 32'(ndone >= target), 32'd1);
  endtask

  task automatic check_idle_reset();
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_tx_req", 32'(ifc.tx_req), 32'd0);
    chk("rst_tx_data", 32'(ifc.tx_data), 32'd0);
    chk("rst_err", 32'(ifc.err), 32'd0);
    chk("rst_count", 32'(ifc.xfer_count), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.rx_ack = 1'b0;
    resp_en = 0;
    space_en = 0;
    tick();
    tick();
    check_idle_reset();
    exp_q.delete();
    prev_wait = 0;
    last_acc = -1;
    rst = 1'b0;
    tick();
    check_idle_reset();
  endtask

  initial begin
    int tgt;
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.rx_ack = 1'b0;

    do_reset();

    // Single transfer with a hand-timed ack
    ifc.in_valid = 1'b1;
    ifc.in_data = 8'h0A;
    exp_q.push_back(8'h0A);
    tick();
    chk("single_tx_data", 32'(ifc.tx_data), 32'h0A);
    chk("single_tx_req", 32'(ifc.tx_req), 32'd1);
    chk("single_in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid = 1'b0;
    ifc.rx_ack = 1'b1;
    tick();
    chk("single_done_e0", 32'(ifc.done), 32'd0);
    tick();
    chk("single_done_e1", 32'(ifc.done), 32'd0);
    tick();
    chk("single_done_e2", 32'(ifc.done), 32'd1);
    chk("single_count", 32'(ifc.xfer_count), 32'd1);
    chk("single_ready", 32'(ifc.in_ready), 32'd1);
    tick();
    chk("single_done_pulse", 32'(ifc.done), 32'd0);

    // Back-to-back with auto responder
    resp_en = 1;
    space_en = 1;
    tgt = ndone + 3;
    send(8'h08);
    send(8'h03);
    send(8'h64);
    ifc.in_valid = 1'b0;
    wait_count(tgt, 60);
    chk("b2b_count", 32'(ifc.xfer_count), 32'd4);
    chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_err", 32'(ifc.err), 32'd0);
    space_en = 0;
    resp_en = 0;
    tick();
    tick();

    // Timeout then late ack
    send(8'h55);
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("to_err_before", 32'(ifc.err), 32'd0);
    tick();
    chk("to_err_set", 32'(ifc.err), 32'd1);
    chk("to_still_wait", 32'(ifc.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("to_still_wait25", 32'(ifc.in_ready), 32'd0);
    tgt = ndone + 1;
    ifc.rx_ack = ifc.tx_req;
    wait_count(tgt, 10);
    chk("to_count", 32'(ifc.xfer_count), 32'd5);
    chk("to_err_sticky", 32'(ifc.err), 32'd1);

    // Spurious ack in IDLE
    do_reset();
    ifc.rx_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("spur_err", 32'(ifc.err), 32'd1);
    chk("spur_ready", 32'(ifc.in_ready), 32'd1);
    chk("spur_req", 32'(ifc.tx_req), 32'd0);

    // Reset mid-transfer
    do_reset();
    send(8'h77);
    ifc.in_valid = 1'b0;
    chk("mid_waiting", 32'(ifc.in_ready), 32'd0);
    chk("mid_req", 32'(ifc.tx_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(ifc.tx_req), 32'd0);
    chk("mid_rst_ready", 32'(ifc.in_ready), 32'd1);
    chk("mid_rst_count", 32'(ifc.xfer_count), 32'd0);
    do_reset();
    resp_en = 1;
    tgt = ndone + 1;
    send(8'h32);
    ifc.in_valid = 1'b0;
    wait_count(tgt, 20);
    chk("post_count", 32'(ifc.xfer_count), 32'd1);
    chk("post_err", 32'(ifc.err), 32'd0);
    chk("post_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
